// File: rtl/fire_codec_arbiter.sv
// Two-requester round-robin front end for a shared encode/decode codec.
// One job is in flight at a time: IDLE grants a requester, RUN drives the
// codec until it reports done (or the cycle budget expires), and RESP
// returns a one-cycle result pulse to the requester that owned the job.
module fire_codec_arbiter #(
    parameter int N       = 64,
    parameter int K       = 40,
    parameter int TIMEOUT = 200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s0_valid,
    input  logic         s0_op,
    input  logic [N-1:0] s0_data,
    output logic         s0_ready,
    input  logic         s1_valid,
    input  logic         s1_op,
    input  logic [N-1:0] s1_data,
    output logic         s1_ready,
    output logic         r0_valid,
    output logic [N-1:0] r0_data,
    output logic         r0_timeout,
    output logic         r1_valid,
    output logic [N-1:0] r1_data,
    output logic         r1_timeout,
    output logic [2:0]   codec_mode,
    output logic [N-1:0] codec_data_in,
    input  logic [N-1:0] codec_data_out,
    input  logic         codec_done,
    output logic         busy
);

    localparam int             CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [2:0]     MODE_IDLE = 3'b000;
    localparam logic [2:0]     MODE_ENC  = 3'b001;
    localparam logic [2:0]     MODE_DEC  = 3'b010;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RESP} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic            op_reg;
    logic            id_reg;
    logic            prio_reg;      // 1 = requester 1 wins the next tie
    logic            busy_reg;
    logic [2:0]      mode_reg;
    logic [N-1:0]    cin_reg;
    logic [1:0]      r_valid_reg;
    logic [1:0]      r_timeout_reg;
    logic [N-1:0]    r_data_reg [2];

    logic            grant0;
    logic            grant1;
    logic            sel_op;
    logic [N-1:0]    sel_data;
    logic [N-1:0]    sel_operand;
    logic [N-1:0]    result_next;

    // Round-robin grant, only offered in IDLE and never while reset is held
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state_reg == ST_IDLE) begin
            if (s1_valid && (!s0_valid || prio_reg))
                grant1 = 1'b1;
            else if (s0_valid)
                grant0 = 1'b1;
        end
    end

    // Operand selection at grant time and result shaping at codec completion
    always_comb begin
        sel_op      = grant1 ? s1_op   : s0_op;
        sel_data    = grant1 ? s1_data : s0_data;
        sel_operand = sel_op ? sel_data : {{(N-K){1'b0}}, sel_data[K-1:0]};
        result_next = op_reg ? {{(N-K){1'b0}}, codec_data_out[K-1:0]} : codec_data_out;
    end

    // Job FSM with all externally visible state registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            op_reg        <= 1'b0;
            id_reg        <= 1'b0;
            prio_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            mode_reg      <= MODE_IDLE;
            cin_reg       <= '0;
            r_valid_reg   <= '0;
            r_timeout_reg <= '0;
            r_data_reg[0] <= '0;
            r_data_reg[1] <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                        op_reg    <= sel_op;
                        id_reg    <= grant1;
                        prio_reg  <= grant0;
                        mode_reg  <= sel_op ? MODE_DEC : MODE_ENC;
                        cin_reg   <= sel_operand;
                    end
                end
                ST_RUN: begin
                    // A done on the final budget cycle still counts as a normal result
                    if (codec_done) begin
                        state_reg             <= ST_RESP;
                        mode_reg              <= MODE_IDLE;
                        r_valid_reg[id_reg]   <= 1'b1;
                        r_data_reg[id_reg]    <= result_next;
                        r_timeout_reg[id_reg] <= 1'b0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg             <= ST_RESP;
                        mode_reg              <= MODE_IDLE;
                        r_valid_reg[id_reg]   <= 1'b1;
                        r_data_reg[id_reg]    <= '0;
                        r_timeout_reg[id_reg] <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_reg   <= ST_IDLE;
                    busy_reg    <= 1'b0;
                    r_valid_reg <= '0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    mode_reg  <= MODE_IDLE;
                end
            endcase
        end
    end

    assign s0_ready      = grant0;
    assign s1_ready      = grant1;
    assign r0_valid      = r_valid_reg[0];
    assign r1_valid      = r_valid_reg[1];
    assign r0_timeout    = r_timeout_reg[0];
    assign r1_timeout    = r_timeout_reg[1];
    assign r0_data       = r_data_reg[0];
    assign r1_data       = r_data_reg[1];
    assign codec_mode    = mode_reg;
    assign codec_data_in = cin_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_fire_codec_arbiter.sv
// Self-checking bench for fire_codec_arbiter: directed vector table,
// hand-written reset / contention / stray-done sequences, and random jobs
// checked against a spec-level model of the expected results.
module tb_fire_codec_arbiter;

    localparam int N       = 64;
    localparam int K       = 40;
    localparam int TIMEOUT = 200;
    localparam logic [63:0] MASK_K = (64'h1 << K) - 64'h1;

    logic         clk = 1'b0;
    logic         rst;
    logic         s0_valid, s0_op, s0_ready;
    logic [N-1:0] s0_data;
    logic         s1_valid, s1_op, s1_ready;
    logic [N-1:0] s1_data;
    logic         r0_valid, r0_timeout, r1_valid, r1_timeout;
    logic [N-1:0] r0_data, r1_data;
    logic [2:0]   codec_mode;
    logic [N-1:0] codec_data_in, codec_data_out;
    logic         codec_done, busy;

    int checks   = 0;
    int failures = 0;

    // Model state: last response seen per port, and who wins the next tie
    logic [63:0] m_rdata [2];
    logic        m_rto   [2];
    int          next_pref;

    typedef struct {
        logic [1:0]  vmask;
        logic        op;
        logic [63:0] data;
        int          delay;
        logic [63:0] out;
        int          exp_id;
        logic [2:0]  exp_mode;
        logic [63:0] exp_cin;
        logic [63:0] exp_rdata;
        logic        exp_to;
    } vec_t;

    vec_t vecs [8];

    fire_codec_arbiter #(.N(N), .K(K), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .s0_valid       (s0_valid),
        .s0_op          (s0_op),
        .s0_data        (s0_data),
        .s0_ready       (s0_ready),
        .s1_valid       (s1_valid),
        .s1_op          (s1_op),
        .s1_data        (s1_data),
        .s1_ready       (s1_ready),
        .r0_valid       (r0_valid),
        .r0_data        (r0_data),
        .r0_timeout     (r0_timeout),
        .r1_valid       (r1_valid),
        .r1_data        (r1_data),
        .r1_timeout     (r1_timeout),
        .codec_mode     (codec_mode),
        .codec_data_in  (codec_data_in),
        .codec_data_out (codec_data_out),
        .codec_done     (codec_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] port_data(input int p);
        return (p == 1) ? r1_data : r0_data;
    endfunction

    function automatic logic port_to(input int p);
        return (p == 1) ? r1_timeout : r0_timeout;
    endfunction

    task automatic clear_model();
        m_rdata[0] = '0; m_rdata[1] = '0;
        m_rto[0]   = 1'b0; m_rto[1] = 1'b0;
        next_pref  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s0_valid = 1'b0; s1_valid = 1'b0; codec_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        s0_valid = 1'b1; s1_valid = 1'b1;
        #1;
        check("rst_ready", {62'd0, s1_ready, s0_ready}, 64'd0);
        check("rst_mode", {61'd0, codec_mode}, 64'd0);
        check("rst_cin", codec_data_in, 64'd0);
        check("rst_flags", {60'd0, r1_valid, r0_valid, r1_timeout, r0_timeout}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_r0_data", r0_data, 64'd0);
        check("rst_r1_data", r1_data, 64'd0);
        s0_valid = 1'b0; s1_valid = 1'b0;
        step();
        rst = 1'b0;
        clear_model();
    endtask

    // Offer one job, drive the codec, and check the whole RUN/RESP/IDLE sequence.
    task automatic run_job(input logic [1:0] vmask, input logic op, input logic [63:0] data,
                           input int delay, input logic [63:0] out, input int exp_id,
                           input logic [2:0] exp_mode, input logic [63:0] exp_cin,
                           input logic [63:0] exp_rdata, input logic exp_to, input string tag);
        bit fin;
        s0_valid = vmask[0]; s1_valid = vmask[1];
        s0_op = op; s1_op = op; s0_data = data; s1_data = data;
        #1;
        check({tag, "_grant"}, {62'd0, s1_ready, s0_ready}, (exp_id == 1) ? 64'd2 : 64'd1);
        step();
        s0_valid = 1'b0; s1_valid = 1'b0;
        next_pref = (exp_id == 1) ? 0 : 1;
        check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        for (int i = 0; i < TIMEOUT; i++) begin
            check({tag, "_run_mode"}, {59'd0, r1_valid, r0_valid, s1_ready, s0_ready, codec_mode},
                  {61'd0, exp_mode});
            check({tag, "_run_cin"}, codec_data_in, exp_cin);
            codec_done     = (i == delay);
            codec_data_out = (i == delay) ? out : {$urandom, $urandom};
            fin = (i == delay) || (i == TIMEOUT - 1);
            step();
            codec_done = 1'b0;
            if (fin) break;
        end
        // RESP cycle: pulse only on the owner, other port untouched
        for (int p = 0; p < 2; p++) begin
            if (p == exp_id) begin
                check({tag, "_rvalid_own"}, {63'd0, (p == 1) ? r1_valid : r0_valid}, 64'd1);
                check({tag, "_rdata"}, port_data(p), exp_rdata);
                check({tag, "_rtimeout"}, {63'd0, port_to(p)}, {63'd0, exp_to});
            end else begin
                check({tag, "_rvalid_other"}, {63'd0, (p == 1) ? r1_valid : r0_valid}, 64'd0);
                check({tag, "_rdata_other"}, port_data(p), m_rdata[p]);
                check({tag, "_rto_other"}, {63'd0, port_to(p)}, {63'd0, m_rto[p]});
            end
        end
        check({tag, "_resp_mode"}, {61'd0, codec_mode}, 64'd0);
        m_rdata[exp_id] = exp_rdata;
        m_rto[exp_id]   = exp_to;
        // A done during RESP must be ignored
        codec_done = 1'b1; codec_data_out = {$urandom, $urandom};
        step();
        codec_done = 1'b0;
        check({tag, "_idle"}, {60'd0, busy, r1_valid, r0_valid, 1'b0}, 64'd0);
        check({tag, "_idle_mode"}, {61'd0, codec_mode}, 64'd0);
        check({tag, "_hold"}, port_data(exp_id), m_rdata[exp_id]);
        $display("job %s req=%0d op=%0d timeout=%0d result=%h", tag, exp_id, op, exp_to, exp_rdata);
    endtask

    initial begin
        logic [1:0]  vm;
        logic        op;
        logic [63:0] d, o, ecin, erd;
        int          dl, eid;
        logic        eto;

        rst = 1'b1;
        s0_valid = 1'b0; s0_op = 1'b0; s0_data = '0;
        s1_valid = 1'b0; s1_op = 1'b0; s1_data = '0;
        codec_done = 1'b0; codec_data_out = '0;
        clear_model();

        vecs[0] = '{2'b01, 1'b0, 64'h0000_0000_DEAD_BEEF, 5, 64'h1234_00DE_ADBE_EF00, 0, 3'b001,
                    64'h0000_0000_DEAD_BEEF, 64'h1234_00DE_ADBE_EF00, 1'b0};
        vecs[1] = '{2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3, 64'hAAAA_AAAA_AAAA_AAAA, 1, 3'b010,
                    64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_00AA_AAAA_AAAA, 1'b0};
        vecs[2] = '{2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h8000_0000_0000_0001, 0, 3'b001,
                    64'h0000_00FF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0};
        vecs[3] = '{2'b10, 1'b0, 64'h0123_4567_89AB_CDEF, TIMEOUT - 1, 64'h5555_5555_5555_5555, 1, 3'b001,
                    64'h0000_0067_89AB_CDEF, 64'h5555_5555_5555_5555, 1'b0};
        vecs[4] = '{2'b01, 1'b1, 64'h0F0F_0F0F_0F0F_0F0F, TIMEOUT + 100, 64'h1111_2222_3333_4444, 0, 3'b010,
                    64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1'b1};
        vecs[5] = '{2'b10, 1'b0, 64'hCAFE_BABE_0000_0001, TIMEOUT + 300, 64'h7777_7777_7777_7777, 1, 3'b001,
                    64'h0000_00BE_0000_0001, 64'h0, 1'b1};
        vecs[6] = '{2'b11, 1'b0, 64'hFFFF_0000_1111_2222, 2, 64'h3333_4444_5555_6666, 0, 3'b001,
                    64'h0000_0000_1111_2222, 64'h3333_4444_5555_6666, 1'b0};
        vecs[7] = '{2'b11, 1'b1, 64'h9876_5432_10FE_DCBA, 4, 64'hFEDC_BA98_7654_3210, 1, 3'b010,
                    64'h9876_5432_10FE_DCBA, 64'h0000_0098_7654_3210, 1'b0};

        do_reset();

        for (int v = 0; v < 8; v++) begin
            run_job(vecs[v].vmask, vecs[v].op, vecs[v].data, vecs[v].delay, vecs[v].out,
                    vecs[v].exp_id, vecs[v].exp_mode, vecs[v].exp_cin, vecs[v].exp_rdata,
                    vecs[v].exp_to, $sformatf("vec%0d", v));
        end

        // Stray done in IDLE: nothing moves
        for (int j = 0; j < 2; j++) begin
            codec_done = 1'b1; codec_data_out = 64'hDEAD_0000_BEEF_0001;
            step();
            codec_done = 1'b0;
            check("stray_state", {60'd0, busy, r1_valid, r0_valid, 1'b0}, 64'd0);
            check("stray_mode", {61'd0, codec_mode}, 64'd0);
            check("stray_r0_data", r0_data, m_rdata[0]);
            check("stray_r1_data", r1_data, m_rdata[1]);
            $display("stray done pulse %0d in IDLE", j);
        end

        // Contention from reset: both requesters held valid, grants alternate from s0
        do_reset();
        s0_op = 1'b0; s1_op = 1'b0; s0_data = 64'h11; s1_data = 64'h22;
        s0_valid = 1'b1; s1_valid = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            eid = j % 2;
            check("cont_grant", {62'd0, s1_ready, s0_ready}, (eid == 1) ? 64'd2 : 64'd1);
            check("cont_idle_mode", {61'd0, codec_mode}, 64'd0);
            step();
            check("cont_run_ready", {62'd0, s1_ready, s0_ready}, 64'd0);
            check("cont_run_mode", {61'd0, codec_mode}, 64'd1);
            check("cont_cin", codec_data_in, (eid == 1) ? 64'h22 : 64'h11);
            codec_done = 1'b1; codec_data_out = 64'h100 + 64'(j);
            step();
            codec_done = 1'b0;
            check("cont_rvalid", {62'd0, r1_valid, r0_valid}, (eid == 1) ? 64'd2 : 64'd1);
            check("cont_rdata", port_data(eid), 64'h100 + 64'(j));
            check("cont_resp_ready", {62'd0, s1_ready, s0_ready}, 64'd0);
            m_rdata[eid] = 64'h100 + 64'(j);
            m_rto[eid]   = 1'b0;
            step();
            $display("contention job %0d granted req=%0d", j, eid);
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        next_pref = 0;

        // Random jobs against the model
        for (int j = 0; j < 20; j++) begin
            vm  = 2'($urandom_range(1, 3));
            op  = 1'($urandom_range(0, 1));
            d   = {$urandom, $urandom};
            o   = {$urandom, $urandom};
            dl  = ($urandom_range(0, 7) == 0) ? TIMEOUT + 5 : int'($urandom_range(0, 15));
            eid = (vm == 2'b01) ? 0 : (vm == 2'b10) ? 1 : next_pref;
            ecin = op ? d : (d & MASK_K);
            eto  = (dl >= TIMEOUT);
            erd  = eto ? 64'd0 : (op ? (o & MASK_K) : o);
            run_job(vm, op, d, dl, o, eid, op ? 3'b010 : 3'b001, ecin, erd, eto,
                    $sformatf("rnd%0d", j));
        end

        // Reset three cycles into RUN: job dropped, pointer back to s0
        s0_valid = 1'b1; s0_op = 1'b0; s0_data = 64'h0000_0012_3456_789A;
        #1;
        check("mid_grant", {62'd0, s1_ready, s0_ready}, 64'd1);
        step();
        s0_valid = 1'b0;
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        check("mid_mode", {61'd0, codec_mode}, 64'd0);
        check("mid_cin", codec_data_in, 64'd0);
        check("mid_busy", {63'd0, busy}, 64'd0);
        s0_valid = 1'b1; s1_valid = 1'b1;
        #1;
        check("mid_ready_in_rst", {62'd0, s1_ready, s0_ready}, 64'd0);
        step();
        check("mid_no_resp", {62'd0, r1_valid, r0_valid}, 64'd0);
        rst = 1'b0;
        clear_model();
        #1;
        check("mid_after_ready", {62'd0, s1_ready, s0_ready}, 64'd1);
        $display("reset mid-job, s0 favoured after release");
        run_job(2'b11, 1'b1, 64'h0A0B_0C0D_0E0F_1011, 6, 64'h2122_2324_2526_2728, 0, 3'b010,
                64'h0A0B_0C0D_0E0F_1011, 64'h0000_0024_2526_2728, 1'b0, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fire_codec_arbiter.md
FIRE_CODEC_ARBITER -- requirements
Module: fire_codec_arbiter

Interface
REQ-001 SHALL have parameter N, default 64, meaning codeword width in bits.
REQ-002 SHALL have parameter K, default 40, meaning message width in bits (K < N).
REQ-003 SHALL have parameter TIMEOUT, default 200, meaning maximum cycles in RUN before abort (>= 2).
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
  clk  input  1  single clock; all state updates on rising edge.
  rst  input  1  reset, asynchronous, active-high.
  s0_valid  input  1  requester 0 has a job.
  s0_op  input  1  requester 0 operation: 0 = encode, 1 = decode.
  s0_data  input  N  requester 0 payload (encode uses bits K-1:0).
  s0_ready  output  1  requester 0 job accepted this cycle.
  s1_valid, s1_op, s1_data, s1_ready  as s0, for requester 1.
  r0_valid  output  1  one-cycle result pulse to requester 0.
  r0_data  output  N  result for requester 0.
  r0_timeout  output  1  result for requester 0 was aborted.
  r1_valid, r1_data, r1_timeout  as r0, for requester 1.
  codec_mode  output  3  to codec: 000 IDLE, 001 ENCODE, 010 DECODE.
  codec_data_in  output  N  to codec: operand.
  codec_data_out  input  N  from codec: result.
  codec_done  input  1  from codec: result valid this cycle.
  busy  output  1  high whenever state is not IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, RUN, RESP; all outputs except s0_ready/s1_ready SHALL be registered.
REQ-006 In IDLE with any sX_valid high, SHALL grant exactly one requester, assert its sX_ready for that cycle only (combinational from state, valids, pointer), latch op, data and requester id, and move to RUN.
REQ-007 Arbitration SHALL be round-robin: if both valid, grant the requester not granted last; if one valid, grant it; pointer updates only on grant.
REQ-008 sX_ready SHALL be 0 in RUN and RESP; at most one sX_ready high per cycle.
REQ-009 In RUN, codec_mode SHALL be 001 for encode or 010 for decode, held constant throughout RUN.
REQ-010 In RUN, codec_data_in SHALL be {(N-K) zeros, data[K-1:0]} for encode and data[N-1:0] for decode, held constant.
REQ-011 A cycle counter SHALL clear on entry to RUN and increment each RUN cycle.
REQ-012 codec_done high in RUN SHALL capture the result and move to RESP; codec_done in IDLE or RESP SHALL be ignored.
REQ-013 Captured result SHALL be codec_data_out[N-1:0] for encode and {(N-K) zeros, codec_data_out[K-1:0]} for decode.
REQ-014 If the counter reaches TIMEOUT-1 with codec_done low, SHALL move to RESP with result 0 and timeout flag 1; codec_done on that same cycle SHALL win (normal result, no timeout).
REQ-015 In RESP, SHALL assert rX_valid for exactly one cycle to the granted requester only, with rX_data and rX_timeout; codec_mode SHALL be 000; next state IDLE.
REQ-016 rX_data and rX_timeout SHALL hold their last value when rX_valid is low; the non-granted response port SHALL be unchanged.
REQ-017 Latency: job accepted at cycle T drives codec from T+1; codec_done at cycle D yields rX_valid at D+1; earliest next accept at D+2.
REQ-018 codec_mode SHALL be 000 in IDLE and RESP (at least one IDLE cycle between jobs).
REQ-019 Responses SHALL NOT be back-pressured; requesters must sink rX_valid when it pulses.

Reset
REQ-020 rst high SHALL immediately force state IDLE, codec_mode 000, codec_data_in 0, r0/r1 valid, data, timeout 0, busy 0, counter 0, round-robin pointer favouring requester 0 next.
REQ-021 rst asserted mid-RUN SHALL abandon the job with no response pulse; no sX_ready while rst high.

Verification
REQ-022 Single encode: s0 op=0, data=40'h00_DEAD_BEEF; codec_done after 5 cycles with out=64'h1234_00DE_ADBE_EF00 -> codec_mode 001, codec_data_in 64'h0000_00DE_ADBE_EF, r0_valid one cycle with that out, r0_timeout 0.
REQ-023 Decode truncation: s1 op=1, data=64'hFFFF_FFFF_FFFF_FFFF; codec out=64'hAAAA_AAAA_AAAA_AAAA -> codec_mode 010, r1_data 64'h0000_00AA_AAAA_AAAA, r0_valid stays 0.
REQ-024 Contention: s0 and s1 valid continuously from reset -> grants alternate s0, s1, s0, s1; one IDLE codec_mode cycle between jobs.
REQ-025 Timeout: codec_done held 0 -> RESP after exactly TIMEOUT cycles in RUN, rX_valid=1, rX_data=0, rX_timeout=1; done on cycle TIMEOUT-1 -> normal result.
REQ-026 Reset mid-job: rst pulse 3 cycles into RUN -> codec_mode 000 immediately, no r0/r1_valid, next job after release granted to s0.
REQ-027 Stray done: codec_done pulsed in IDLE -> no state change, no response.
